// File: rtl/cpu_controller_if.sv
// cpu_controller_if: instruction-source inputs and datapath control outputs of cpu_controller.
// master = controller side, slave = instruction source / datapath side.
interface cpu_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALU_op;
  logic [15:0] sximm8;
  logic        illegal;

  modport master (
    input  in, load, s,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, vsel, shift, ALU_op, sximm8, illegal
  );

  modport slave (
    output in, load, s,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, vsel, shift, ALU_op, sximm8, illegal
  );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle sequencer for the simple RISC datapath. Holds the instruction
// register, decodes MOV/ALU instructions and drives Moore control outputs per state.
// Optional macro CTRL_FLAG_ALL_EN: when defined, EXEC updates the status register for every
// ALU/MOV-reg instruction instead of only for CMP.
module cpu_controller (
  input  logic              clk,
  input  logic              reset,
  cpu_controller_if.master  ctrl
);

  localparam logic [2:0] ST_WAIT      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_WRITE_IMM = 3'd2;
  localparam logic [2:0] ST_GET_A     = 3'd3;
  localparam logic [2:0] ST_GET_B     = 3'd4;
  localparam logic [2:0] ST_EXEC      = 3'd5;
  localparam logic [2:0] ST_WRITE_REG = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [15:0] r_ir;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [1:0]  w_sh;
  logic [2:0]  w_rm;
  logic        w_mov_imm;
  logic        w_mov_reg;
  logic        w_alu;
  logic        w_cmp;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];

  assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_alu     = (w_opcode == 3'b101);
  assign w_cmp     = w_alu && (w_op == 2'b01);

  // IR loads only while idle so it stays stable for the whole instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir <= 16'h0000;
    end else if ((r_state == ST_WAIT) && ctrl.load) begin
      r_ir <= ctrl.in;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state sequencing.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT: begin
        if (ctrl.s) w_state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_mov_imm) begin
          w_state_next = ST_WRITE_IMM;
        end else if (w_mov_reg || (w_alu && (w_op == 2'b11))) begin
          w_state_next = ST_GET_B;
        end else if (w_alu) begin
          w_state_next = ST_GET_A;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WRITE_IMM: w_state_next = ST_WAIT;
      ST_GET_A:     w_state_next = ST_GET_B;
      ST_GET_B:     w_state_next = ST_EXEC;
      ST_EXEC:      w_state_next = w_cmp ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: w_state_next = ST_WAIT;
      default:      w_state_next = ST_WAIT;
    endcase
  end

  // Moore control outputs; anything not driven in a state stays 0.
  always_comb begin
    ctrl.w        = 1'b0;
    ctrl.readnum  = 3'd0;
    ctrl.writenum = 3'd0;
    ctrl.write    = 1'b0;
    ctrl.loada    = 1'b0;
    ctrl.loadb    = 1'b0;
    ctrl.loadc    = 1'b0;
    ctrl.loads    = 1'b0;
    ctrl.asel     = 1'b0;
    ctrl.vsel     = 2'b00;
    ctrl.shift    = 2'b00;
    ctrl.ALU_op   = 2'b00;
    ctrl.illegal  = 1'b0;
    case (r_state)
      ST_WAIT: ctrl.w = 1'b1;
      ST_DECODE: ctrl.illegal = !(w_mov_imm || w_mov_reg || w_alu);
      ST_WRITE_IMM: begin
        ctrl.writenum = w_rn;
        ctrl.vsel     = 2'b10;
        ctrl.write    = 1'b1;
      end
      ST_GET_A: begin
        ctrl.readnum = w_rn;
        ctrl.loada   = 1'b1;
      end
      ST_GET_B: begin
        ctrl.readnum = w_rm;
        ctrl.loadb   = 1'b1;
      end
      ST_EXEC: begin
        ctrl.shift  = w_sh;
        ctrl.ALU_op = w_alu ? w_op : 2'b00;
        // MOV reg computes 0 + shifted Rm.
        ctrl.asel   = w_mov_reg;
        ctrl.loadc  = !w_cmp;
`ifdef CTRL_FLAG_ALL_EN
        ctrl.loads  = 1'b1;
`else
        ctrl.loads  = w_cmp;
`endif
      end
      ST_WRITE_REG: begin
        ctrl.writenum = w_rd;
        ctrl.write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl.sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed vectors for cpu_controller. Stimulus pushes the per-cycle
// expected control word into a queue; the monitor pops and compares one entry per cycle.
module tb_cpu_controller;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;
    logic        illegal;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } item_t;

`ifdef CTRL_FLAG_ALL_EN
  localparam bit AllEn = 1'b1;
`else
  localparam bit AllEn = 1'b0;
`endif

  logic clk;
  logic reset;
  cpu_controller_if bus ();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t       q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] last_ir = 16'h0000;
  ctl_t        act;

  assign act = {bus.w, bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb, bus.loadc,
                bus.loads, bus.asel, bus.vsel, bus.shift, bus.ALU_op, bus.sximm8, bus.illegal};

  // Monitor: one expected control word per cycle, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    item_t it;
    if (q.size() > 0) begin
      it = q.pop_front();
      n_tests++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  function automatic ctl_t base(logic [15:0] ir);
    ctl_t c;
    c        = '0;
    c.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return c;
  endfunction

  function automatic ctl_t v_wait(logic [15:0] ir);
    ctl_t c = base(ir);
    c.w = 1'b1;
    return c;
  endfunction

  function automatic ctl_t v_dec(logic [15:0] ir, logic ill);
    ctl_t c = base(ir);
    c.illegal = ill;
    return c;
  endfunction

  function automatic ctl_t v_imm(logic [15:0] ir, logic [2:0] wn);
    ctl_t c = base(ir);
    c.writenum = wn;
    c.vsel     = 2'b10;
    c.write    = 1'b1;
    return c;
  endfunction

  function automatic ctl_t v_ga(logic [15:0] ir, logic [2:0] rn);
    ctl_t c = base(ir);
    c.readnum = rn;
    c.loada   = 1'b1;
    return c;
  endfunction

  function automatic ctl_t v_gb(logic [15:0] ir, logic [2:0] rm);
    ctl_t c = base(ir);
    c.readnum = rm;
    c.loadb   = 1'b1;
    return c;
  endfunction

  // is_cmp selects CMP behaviour: status load, no C load.
  function automatic ctl_t v_ex(logic [15:0] ir, logic [1:0] sh, logic [1:0] op, logic asel,
                                logic is_cmp);
    ctl_t c = base(ir);
    c.shift  = sh;
    c.alu_op = op;
    c.asel   = asel;
    c.loadc  = !is_cmp;
    c.loads  = is_cmp | AllEn;
    return c;
  endfunction

  function automatic ctl_t v_wr(logic [15:0] ir, logic [2:0] wn);
    ctl_t c = base(ir);
    c.writenum = wn;
    c.write    = 1'b1;
    return c;
  endfunction

  task automatic push(input string name, input ctl_t c);
    item_t it;
    it.name = name;
    it.exp  = c;
    q.push_back(it);
  endtask

  // Wait for the monitor to consume every queued expectation, bounded.
  task automatic drain(input string name);
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Load and start in the same edge; optionally try a load/start while busy.
  task automatic exec(input logic [15:0] instr, input bit busy_load, input string name);
    bus.in   = instr;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.s    = 1'b0;
    if (busy_load) begin
      bus.in   = 16'h1234;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      bus.s    = 1'b0;
    end
    last_ir = instr;
    drain(name);
  endtask

  initial begin
    reset    = 1'b1;
    bus.in   = 16'h0000;
    bus.load = 1'b0;
    bus.s    = 1'b0;
    push("reset", v_wait(16'h0000));
    @(negedge clk);
    #1;
    reset = 1'b0;
    drain("reset");

    // MOV R1,#5: 3-cycle latency
    push("movimm_wait", v_wait(last_ir));
    push("movimm_dec",  v_dec(16'hD105, 1'b0));
    push("movimm_wr",   v_imm(16'hD105, 3'd1));
    push("movimm_done", v_wait(16'hD105));
    exec(16'hD105, 1'b0, "movimm");

    // MOV R2,#-1: sign extension
    push("movneg_wait", v_wait(last_ir));
    push("movneg_dec",  v_dec(16'hD2FF, 1'b0));
    push("movneg_wr",   v_imm(16'hD2FF, 3'd2));
    push("movneg_done", v_wait(16'hD2FF));
    exec(16'hD2FF, 1'b0, "movneg");

    // ADD R5,R0,R1 (sh=01), with a load attempt while busy
    push("add_wait", v_wait(last_ir));
    push("add_dec",  v_dec(16'hA0A9, 1'b0));
    push("add_geta", v_ga(16'hA0A9, 3'd0));
    push("add_getb", v_gb(16'hA0A9, 3'd1));
    push("add_exec", v_ex(16'hA0A9, 2'b01, 2'b00, 1'b0, 1'b0));
    push("add_wreg", v_wr(16'hA0A9, 3'd5));
    push("add_done", v_wait(16'hA0A9));
    exec(16'hA0A9, 1'b1, "add");

    // CMP R1,R0,LSL#1: no write, 4-cycle latency
    push("cmp_wait", v_wait(last_ir));
    push("cmp_dec",  v_dec(16'hA948, 1'b0));
    push("cmp_geta", v_ga(16'hA948, 3'd1));
    push("cmp_getb", v_gb(16'hA948, 3'd0));
    push("cmp_exec", v_ex(16'hA948, 2'b01, 2'b01, 1'b0, 1'b1));
    push("cmp_done", v_wait(16'hA948));
    exec(16'hA948, 1'b0, "cmp");

    // MVN R7,R2
    push("mvn_wait", v_wait(last_ir));
    push("mvn_dec",  v_dec(16'hB8E2, 1'b0));
    push("mvn_getb", v_gb(16'hB8E2, 3'd2));
    push("mvn_exec", v_ex(16'hB8E2, 2'b00, 2'b11, 1'b0, 1'b0));
    push("mvn_wreg", v_wr(16'hB8E2, 3'd7));
    push("mvn_done", v_wait(16'hB8E2));
    exec(16'hB8E2, 1'b0, "mvn");

    // MOV R3,R4,sh=10: asel forces A to zero
    push("movreg_wait", v_wait(last_ir));
    push("movreg_dec",  v_dec(16'hC074, 1'b0));
    push("movreg_getb", v_gb(16'hC074, 3'd4));
    push("movreg_exec", v_ex(16'hC074, 2'b10, 2'b00, 1'b1, 1'b0));
    push("movreg_wreg", v_wr(16'hC074, 3'd3));
    push("movreg_done", v_wait(16'hC074));
    exec(16'hC074, 1'b0, "movreg");

    // AND R6,R3,R5,sh=11
    push("and_wait", v_wait(last_ir));
    push("and_dec",  v_dec(16'hB3DD, 1'b0));
    push("and_geta", v_ga(16'hB3DD, 3'd3));
    push("and_getb", v_gb(16'hB3DD, 3'd5));
    push("and_exec", v_ex(16'hB3DD, 2'b11, 2'b10, 1'b0, 1'b0));
    push("and_wreg", v_wr(16'hB3DD, 3'd6));
    push("and_done", v_wait(16'hB3DD));
    exec(16'hB3DD, 1'b0, "and");

    // Illegal opcode 111
    push("ill7_wait", v_wait(last_ir));
    push("ill7_dec",  v_dec(16'hE000, 1'b1));
    push("ill7_done", v_wait(16'hE000));
    exec(16'hE000, 1'b0, "ill7");

    // Illegal 110/01
    push("ill6_wait", v_wait(last_ir));
    push("ill6_dec",  v_dec(16'hC800, 1'b1));
    push("ill6_done", v_wait(16'hC800));
    exec(16'hC800, 1'b0, "ill6");

    // Reset asserted mid-GET_A of ADD
    push("rst_wait", v_wait(last_ir));
    push("rst_dec",  v_dec(16'hA0A9, 1'b0));
    push("rst_geta", v_ga(16'hA0A9, 3'd0));
    push("rst_idle", v_wait(16'h0000));
    bus.in   = 16'hA0A9;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.s    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    last_ir = 16'h0000;
    drain("rst");

    // Normal operation after the mid-instruction reset
    push("post_wait", v_wait(last_ir));
    push("post_dec",  v_dec(16'hD105, 1'b0));
    push("post_wr",   v_imm(16'hD105, 3'd1));
    push("post_done", v_wait(16'hD105));
    exec(16'hD105, 1'b0, "post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
